// File: rtl/dense_layer_seq.sv
// dense_layer_seq: time-multiplexed fully-connected layer, one MAC per clock.
// Mode 3 is PWL softplus when DENSE_SOFTPLUS_EN is defined, else identity.
module dense_layer_seq #(
  parameter int N_IN   = 9,
  parameter int N_OUT  = 9,
  parameter int IN_W   = 1,
  parameter int DATA_W = 20,
  parameter int FRAC_W = 12,
  localparam int AW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   in_data,
  input  logic [1:0]             cfg_act,
  input  logic                   wr_en,
  input  logic                   wr_is_bias,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [OW-1:0]          out_idx,
  output logic                   out_last,
  output logic                   busy
);

  localparam int KW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int ACC_W = DATA_W + IN_W + $clog2(N_IN) + 1;
  localparam int PW    = DATA_W + IN_W + 1;
  localparam int HW    = DATA_W + 2;
  localparam int NW    = N_IN * N_OUT;

  localparam logic signed [ACC_W-1:0] SMAX =
    ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SMIN =
    ACC_W'(-(2 ** (DATA_W - 1)));
  localparam logic signed [HW-1:0] ONE  = HW'(1 << FRAC_W);
  localparam logic signed [HW-1:0] HALF = HW'(1 << (FRAC_W - 1));

  typedef enum logic [1:0] {
    IDLE, MAC, ACT, OUT
  } state_t;

  state_t state, next;

  logic [N_IN*IN_W-1:0]      in_q;
  logic [1:0]                act_q;
  logic [OW-1:0]             j;
  logic [KW-1:0]             k;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  wmem [NW];
  logic signed [DATA_W-1:0]  bmem [N_OUT];

  logic [AW-1:0]             w_addr;
  logic [IN_W-1:0]           elem;
  logic signed [PW-1:0]      prod;
  logic signed [DATA_W-1:0]  sat;
  logic signed [HW-1:0]      satw;
  logic signed [HW-1:0]      hs;
  logic signed [DATA_W-1:0]  act_res;
  logic                      wr_ok;
  logic                      k_last;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign k_last   = (k == KW'(N_IN - 1));

  assign w_addr = AW'(32'(j) * N_IN + 32'(k));
  assign elem   = in_q[32'(k) * IN_W +: IN_W];
  assign prod   = PW'(wmem[w_addr]) *
                  PW'($signed({1'b0, elem}));

  assign wr_ok = wr_en && (state == IDLE) &&
                 (wr_is_bias ? (32'(wr_addr) < N_OUT)
                             : (32'(wr_addr) < NW));

  // saturate the accumulator to the output width
  always_comb begin
    sat = DATA_W'(acc);
    if (acc > SMAX)
      sat = DATA_W'(SMAX);
    else if (acc < SMIN)
      sat = DATA_W'(SMIN);
  end

  assign satw = HW'(sat);
  assign hs   = HW'(sat >>> 2) + HALF;

`ifdef DENSE_SOFTPLUS_EN
  localparam int SQW = 2 * HW;
  localparam logic signed [HW-1:0] TWO = HW'(2 << FRAC_W);

  logic signed [HW-1:0] sh;
  logic [SQW-1:0]       sq;
  logic signed [DATA_W-1:0] sp;

  assign sh = satw + TWO;
  assign sq = SQW'($unsigned(sh)) * SQW'($unsigned(sh));

  // quadratic knee between -2 and +2, linear/zero outside
  always_comb begin
    sp = DATA_W'(sq >> (FRAC_W + 3));
    if (satw <= -TWO)
      sp = '0;
    else if (satw >= TWO)
      sp = sat;
  end
`endif

  // activation select on the latched mode
  always_comb begin
    act_res = sat;
    case (act_q)
      2'd1: begin
        if (hs < 0)
          act_res = '0;
        else if (hs > ONE)
          act_res = DATA_W'(ONE);
        else
          act_res = DATA_W'(hs);
      end
      2'd2: act_res = sat[DATA_W-1] ? '0 : sat;
`ifdef DENSE_SOFTPLUS_EN
      2'd3: act_res = sp;
`endif
      default: act_res = sat;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next;
  end

  // next-state logic
  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (in_valid) next = MAC;
      MAC:  if (k_last) next = ACT;
      ACT:  next = OUT;
      OUT:  if (out_ready) next = out_last ? IDLE : MAC;
      default: next = IDLE;
    endcase
  end

  // datapath: bias is folded in on the first MAC so same-cycle
  // writes at accept are already visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q      <= '0;
      act_q     <= '0;
      j         <= '0;
      k         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_q  <= in_data;
            act_q <= cfg_act;
            j     <= '0;
            k     <= '0;
          end
        end
        MAC: begin
          acc <= ((k == '0) ? ACC_W'(bmem[j]) : acc) +
                 ACC_W'(prod);
          k   <= k_last ? '0 : k + 1'b1;
        end
        ACT: begin
          out_data  <= act_res;
          out_idx   <= j;
          out_last  <= (j == OW'(N_OUT - 1));
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!out_last) begin
              j <= j + 1'b1;
              k <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // weight/bias storage and write rejection flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++)
        wmem[i] <= '0;
      for (int i = 0; i < N_OUT; i++)
        bmem[i] <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      if (wr_ok) begin
        if (wr_is_bias)
          bmem[OW'(wr_addr)] <= wr_data;
        else
          wmem[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: doc/dense_layer_seq.md
Name: dense_layer_seq

Overview:
- Time-multiplexed, parametrised fully-connected layer for the VAE datapath: one multiply-accumulate (MAC) per clock, any N_IN×N_OUT size, selectable activation.
- Replaces hard-wired parallel neuron instances with one MAC plus on-chip weight/bias storage, loaded through a write port.
- Takes an input vector over a valid/ready handshake and streams N_OUT activated results, one per handshake.

Parameters:
N_IN, 9, inputs per neuron
N_OUT, 9, neurons per layer
IN_W, 1, width of each unsigned input element (1 = binary pixel)
DATA_W, 20, signed weight/bias/output width
FRAC_W, 12, fractional bits of weights/bias/output (Q format)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  high only in IDLE
in_data  in  N_IN*IN_W  element k at bits [k*IN_W +: IN_W]
cfg_act  in  2  activation mode, sampled at input accept
wr_en  in  1  weight/bias write strobe
wr_is_bias  in  1  1 = bias memory, 0 = weight memory
wr_addr  in  clog2(N_IN*N_OUT)  weight addr j*N_IN+k, or bias addr j
wr_data  in  DATA_W  signed value to write
wr_err  out  1  one-cycle pulse: write rejected
out_valid  out  1  result valid
out_ready  in  1  result accepted
out_data  out  DATA_W  signed activated result
out_idx  out  clog2(N_OUT)  neuron index j
out_last  out  1  high with the result for j = N_OUT-1
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, wr_err=0, busy=0, in_ready=1 once rst_n is released.
  - Weight and bias memories cleared to 0.
  - A reset in any state aborts the operation in progress; no partial output.
- States: IDLE -> MAC -> ACT -> OUT -> (MAC | IDLE).
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch in_data and cfg_act, set j=0, k=0, acc=bias[j], go to MAC.
- MAC:
  - Each cycle: acc += weight[j*N_IN+k] * in_elem[k], where in_elem is unsigned and zero-extended.
  - k increments; after k = N_IN-1, go to ACT. Exactly N_IN cycles.
- Accumulator width: ACC_W = DATA_W+IN_W+clog2(N_IN)+1, signed, never overflows. No fractional shift, since inputs are integers.
- ACT (1 cycle):
  - sat = acc saturated to DATA_W signed (0x7FFFF / 0x80000 at defaults).
  - Apply activation and register out_data, out_idx=j, out_last=(j==N_OUT-1), out_valid=1. Go to OUT.
- Activation modes, with ONE = 1<<FRAC_W:
  - 0: identity.
  - 1: hard sigmoid, clamp((sat>>>2) + ONE/2, 0, ONE).
  - 2: ReLU, max(sat, 0).
  - 3: see Optional Feature.
- OUT:
  - Hold out_data, out_idx and out_last stable while out_valid & !out_ready.
  - On out_ready: out_valid=0. If out_last, go to IDLE; else j++, k=0, acc=bias[j], go to MAC.
- Latency: accept at edge 0 -> out_valid high after edge N_IN+1. Each further neuron takes N_IN+1 cycles after the previous handshake.
- Writes:
  - Accepted only in IDLE, and only when the address is in range (< N_IN*N_OUT for weights, < N_OUT for biases).
  - Otherwise no memory change and wr_err pulses high on the following cycle.
  - A write in the same cycle as an input accept is applied, and the new value is visible to that computation.

Optional Feature:
- Macro: DENSE_SOFTPLUS_EN.
- Defined: mode 3 = PWL softplus:
  - 0 if sat <= -2*ONE.
  - sat if sat >= 2*ONE.
  - otherwise ((sat + 2*ONE)^2) >> (FRAC_W+3).
  - Registered in ACT; latency unchanged.
- Undefined: mode 3 behaves as identity (mode 0); no squaring multiplier is synthesised.

Test Plan:
1. All weights 0x01000, biases 0, in_data=9'h1FF, mode 0 -> nine outputs 0x09000, out_idx 0..8, out_last only on idx 8, first out_valid 10 cycles after accept, in_ready=0 until the last handshake.
2. Weights 0x7FFFF, in all ones, mode 0 -> every out_data=0x7FFFF. Weights 0x80000 -> 0x80000 (saturation).
3. Weights 0, mode 1, bias 0 / 0x02000 / 0xFE000 -> out_data 0x00800 / 0x01000 / 0x00000. Mode 2 with bias 0xFE000 -> 0.
4. out_ready held low 5 cycles on idx 3 -> out_data and out_idx stable, no idx 4 produced, busy=1; release -> sequence resumes with correct values.
5. wr_en during MAC, or weight addr 81 -> wr_err pulse, memory read-back via computation unchanged.
6. Mode 3, weights 0, bias 0 -> 0x00800 with DENSE_SOFTPLUS_EN, 0x00000 without. Separately, rst_n low mid-MAC -> out_valid=0 immediately, in_ready=1 after release, outputs computed 0 (memories cleared).
